// File: rtl/zeroriscy_prefetch_buf_if.sv
// ---------------------------------------------------------------------------
// zeroriscy_prefetch_buf_if
//
// Groups the two handshakes of the prefetch buffer into one bundle:
//   memory side : instr_req / instr_addr / instr_gnt    (request/grant)
//                 instr_rvalid / instr_rdata / instr_err (in-order response)
//   core side   : fetch_valid / fetch_ready             (valid/ready pop)
//                 fetch_rdata / fetch_addr / fetch_err  (head entry payload)
//
// Modports:
//   master - the prefetch buffer (issues memory requests, offers fetch words)
//   slave  - the environment (memory plus core) seen from the other side
// ---------------------------------------------------------------------------
interface zeroriscy_prefetch_buf_if;

  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;
  logic        instr_err;

  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_rdata;
  logic [31:0] fetch_addr;
  logic        fetch_err;

  modport master (
    output instr_req, instr_addr,
    input  instr_gnt, instr_rvalid, instr_rdata, instr_err,
    output fetch_valid, fetch_rdata, fetch_addr, fetch_err,
    input  fetch_ready
  );

  modport slave (
    input  instr_req, instr_addr,
    output instr_gnt, instr_rvalid, instr_rdata, instr_err,
    input  fetch_valid, fetch_rdata, fetch_addr, fetch_err,
    output fetch_ready
  );

endinterface

// File: rtl/zeroriscy_prefetch_buf.sv
// ---------------------------------------------------------------------------
// zeroriscy_prefetch_buf
//
// Instruction prefetch buffer. Issues sequential word fetches to an
// in-order memory, stores the returned words in a small FIFO and hands
// them to the core. A branch flushes the FIFO and any responses still in
// flight are dropped as they arrive.
//
// Parameters:
//   DEPTH   - FIFO entries (power of two, 2..16)
//   MAX_OUT - maximum memory requests in flight (1..DEPTH)
//
// Ports:
//   clk         - clock, everything on the rising edge
//   rst         - synchronous active-high reset
//   boot_addr   - fetch start address, loaded while rst=1
//   fetch_en    - allows new memory requests
//   branch      - one-cycle redirect strobe
//   branch_addr - redirect target
//   bus         - memory request/response and core fetch handshakes
// ---------------------------------------------------------------------------
module zeroriscy_prefetch_buf #(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] boot_addr,
  input  logic        fetch_en,
  input  logic        branch,
  input  logic [31:0] branch_addr,
  zeroriscy_prefetch_buf_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);
  localparam logic [AW-1:0] AQ_LAST   = AW'(MAX_OUT - 1);

  logic [31:0]   fetch_pc;
  logic          req_held;
  logic          redirect_pending;
  logic [31:0]   redirect_target;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_d;
  logic [CW-1:0] discard_cnt;
  logic [CW-1:0] discard_d;

  logic [31:0]   fifo_data [DEPTH];
  logic [31:0]   fifo_addr [DEPTH];
  logic          fifo_err  [DEPTH];
  logic [PW-1:0] fifo_rptr;
  logic [PW-1:0] fifo_wptr;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] fifo_count_d;

  logic [31:0]   aq_addr [MAX_OUT];
  logic [AW-1:0] aq_rptr;
  logic [AW-1:0] aq_wptr;

  logic          new_req;
  logic          req;
  logic          grant;
  logic          rsp;
  logic          drop;
  logic          push;
  logic          pop;
  logic          hold_branch;
  logic          redirect_grant;
  logic          valid;
  logic [CW:0]   occupancy;

  function automatic logic [AW-1:0] aq_next(input logic [AW-1:0] p);
    return (p == AQ_LAST) ? '0 : p + AW'(1);
  endfunction

  // Every granted request eventually lands in the FIFO, so FIFO words plus
  // requests in flight must never exceed the FIFO size.
  assign occupancy = {1'b0, fifo_count} + {1'b0, outstanding};

  // A fresh request is only started when nothing is being held; once a
  // request is up it stays up with a stable address until it is granted.
  assign new_req = fetch_en & ~branch & ~redirect_pending & ~req_held &
                   (outstanding < MAX_OUT_C) & (occupancy < {1'b0, DEPTH_C});
  assign req     = ~rst & (req_held | new_req);
  assign grant   = req & bus.instr_gnt;

  assign rsp  = bus.instr_rvalid;
  assign drop = rsp & (discard_cnt != '0);

  // A branch that lands on a held request cannot move the address yet; the
  // target is parked until that request is granted.
  assign hold_branch    = branch & req_held & ~bus.instr_gnt;
  assign redirect_grant = grant & redirect_pending & ~branch;

  // Branch wins over both FIFO ports in its cycle.
  assign valid = ~rst & (fifo_count != '0);
  assign push  = rsp & ~drop & ~branch;
  assign pop   = valid & bus.fetch_ready & ~branch;

  assign bus.instr_req   = req;
  assign bus.instr_addr  = fetch_pc;
  assign bus.fetch_valid = valid;
  assign bus.fetch_rdata = valid ? fifo_data[fifo_rptr] : '0;
  assign bus.fetch_addr  = valid ? fifo_addr[fifo_rptr] : '0;
  assign bus.fetch_err   = valid ? fifo_err[fifo_rptr]  : 1'b0;

  // In-flight count: up on a grant, down on a response, unchanged on both.
  always_comb begin
    outstanding_d = outstanding;
    if (grant && !rsp) begin
      outstanding_d = outstanding + CW'(1);
    end else if (!grant && rsp) begin
      outstanding_d = outstanding - CW'(1);
    end
  end

  // After a branch every request in flight (including one granted in the
  // branch cycle) is stale, which is exactly next cycle's in-flight count.
  // Later, the parked request's grant adds one more stale response.
  always_comb begin
    discard_d = discard_cnt;
    if (branch) begin
      discard_d = outstanding_d;
    end else if (redirect_grant && !drop) begin
      discard_d = discard_cnt + CW'(1);
    end else if (!redirect_grant && drop) begin
      discard_d = discard_cnt - CW'(1);
    end
  end

  // FIFO occupancy; a branch empties it regardless of push or pop.
  always_comb begin
    fifo_count_d = fifo_count;
    if (branch) begin
      fifo_count_d = '0;
    end else if (push && !pop) begin
      fifo_count_d = fifo_count + CW'(1);
    end else if (pop && !push) begin
      fifo_count_d = fifo_count - CW'(1);
    end
  end

  // Control state: fetch address, held request, redirect bookkeeping,
  // counters and pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc         <= boot_addr & 32'hFFFF_FFFC;
      req_held         <= 1'b0;
      redirect_pending <= 1'b0;
      redirect_target  <= '0;
      outstanding      <= '0;
      discard_cnt      <= '0;
      fifo_count       <= '0;
      fifo_rptr        <= '0;
      fifo_wptr        <= '0;
      aq_rptr          <= '0;
      aq_wptr          <= '0;
    end else begin
      outstanding <= outstanding_d;
      discard_cnt <= discard_d;
      fifo_count  <= fifo_count_d;
      req_held    <= req & ~bus.instr_gnt;

      if (branch && !hold_branch) begin
        fetch_pc <= branch_addr & 32'hFFFF_FFFC;
      end else if (redirect_grant) begin
        fetch_pc <= redirect_target;
      end else if (grant && !branch) begin
        fetch_pc <= fetch_pc + 32'd4;
      end

      if (hold_branch) begin
        redirect_pending <= 1'b1;
        redirect_target  <= branch_addr & 32'hFFFF_FFFC;
      end else if (branch || redirect_grant) begin
        redirect_pending <= 1'b0;
      end

      if (branch) begin
        fifo_rptr <= '0;
        fifo_wptr <= '0;
      end else begin
        if (push) begin
          fifo_wptr <= fifo_wptr + PW'(1);
        end
        if (pop) begin
          fifo_rptr <= fifo_rptr + PW'(1);
        end
      end

      if (grant) begin
        aq_wptr <= aq_next(aq_wptr);
      end
      if (rsp) begin
        aq_rptr <= aq_next(aq_rptr);
      end
    end
  end

  // Storage arrays: the address queue remembers each granted address so a
  // response (which carries only data) can be tagged with where it came from.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[fifo_wptr] <= bus.instr_rdata;
      fifo_addr[fifo_wptr] <= aq_addr[aq_rptr];
      fifo_err[fifo_wptr]  <= bus.instr_err;
    end
    if (grant) begin
      aq_addr[aq_wptr] <= fetch_pc;
    end
  end

endmodule

// File: doc/zeroriscy_prefetch_buf.md
ZERORISCY_PREFETCH_BUF -- requirements
Module: zeroriscy_prefetch_buf

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL have parameter DEPTH, 4, FIFO entries (power of 2, 2..16).
REQ-003 SHALL have parameter MAX_OUT, 2, max in-flight memory requests (1..DEPTH).
REQ-004 SHALL have port clk  in  1  clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous active-high reset.
REQ-006 SHALL have port boot_addr  in  32  fetch start address, sampled during reset.
REQ-007 SHALL have port fetch_en  in  1  permits issue of new memory requests.
REQ-008 SHALL have port branch  in  1  one-cycle redirect strobe.
REQ-009 SHALL have port branch_addr  in  32  redirect target.
REQ-010 SHALL have port instr_req  out  1  memory request.
REQ-011 SHALL have port instr_addr  out  32  word-aligned request address.
REQ-012 SHALL have port instr_gnt  in  1  memory accepted request this cycle.
REQ-013 SHALL have port instr_rvalid  in  1  response data valid.
REQ-014 SHALL have port instr_rdata  in  32  response data.
REQ-015 SHALL have port instr_err  in  1  response error, qualified by instr_rvalid.
REQ-016 SHALL have port fetch_valid  out  1  buffered instruction available.
REQ-017 SHALL have port fetch_ready  in  1  core consumes head entry when fetch_valid=1.
REQ-018 SHALL have port fetch_rdata  out  32  head instruction word.
REQ-019 SHALL have port fetch_addr  out  32  address of head word.
REQ-020 SHALL have port fetch_err  out  1  error flag of head word.

Function
REQ-021 SHALL keep fetch_pc (next issue address); bits [1:0] always 0; increments by 4 per grant, wrapping 0xFFFFFFFC -> 0x00000000.
REQ-022 SHALL drive instr_addr = fetch_pc while instr_req=1.
REQ-023 SHALL assert instr_req new when fetch_en=1, branch=0, redirect_pending=0, outstanding<MAX_OUT, and fifo_count+outstanding<DEPTH.
REQ-024 SHALL, once instr_req=1 with instr_gnt=0, hold instr_req=1 and instr_addr unchanged until instr_gnt=1, regardless of fetch_en or branch.
REQ-025 SHALL increment outstanding on req&gnt and decrement on instr_rvalid; both in one cycle leaves it unchanged.
REQ-026 SHALL treat responses as in-order, one per granted request, latency >=1 cycle after grant.
REQ-027 SHALL write {instr_rdata, address, instr_err} into FIFO tail on instr_rvalid when discard_cnt=0; address is a separate per-request address queue of MAX_OUT entries.
REQ-028 SHALL present FIFO head on fetch_rdata/fetch_addr/fetch_err with fetch_valid=(fifo_count>0); write-to-valid latency 1 cycle (no bypass).
REQ-029 SHALL pop head when fetch_valid&fetch_ready; simultaneous push and pop keeps fifo_count; push never occurs when full (guaranteed by REQ-023).
REQ-030 SHALL, on branch=1 with no held request: empty FIFO, set discard_cnt=outstanding minus (1 if instr_rvalid this cycle), set fetch_pc=branch_addr&~3, instr_req=0 that cycle.
REQ-031 SHALL, on branch=1 while a request is held: empty FIFO, set redirect_pending with target; on that request's grant count it as discarded and load fetch_pc from target next cycle, clearing redirect_pending.
REQ-032 SHALL drop instr_rvalid responses while discard_cnt>0, decrementing discard_cnt per drop.
REQ-033 SHALL give branch priority over same-cycle pop and push (both ignored, FIFO empty next cycle).
REQ-034 SHALL make a second branch while redirect_pending overwrite the pending target.
REQ-035 SHALL with fetch_en=0 issue nothing new but still complete outstanding responses into FIFO.
REQ-036 SHALL, with 1-cycle-latency always-granting memory and fetch_ready=1, sustain one fetch_valid word per cycle after startup.

Reset
REQ-037 SHALL while rst=1 set fetch_pc=boot_addr&~3, FIFO empty, outstanding=0, discard_cnt=0, redirect_pending=0, instr_req=0, fetch_valid=0; fetch_rdata/fetch_addr/fetch_err=0.
REQ-038 SHALL discard all in-flight state on reset mid-operation; responses arriving after rst deasserts for pre-reset requests are not supported.

Verification
REQ-039 SHALL test boot: boot_addr=0x80000002, release rst, fetch_en=1, always-grant 1-cycle memory -> instr_addr 0x80000000 first cycle, fetch_valid next-next cycle with fetch_addr 0x80000000, then +4 each cycle.
REQ-040 SHALL test backpressure: fetch_ready=0 -> exactly DEPTH words buffered, instr_req low, no overflow; release -> words in address order, none lost.
REQ-041 SHALL test branch with 2 outstanding, branch_addr=0x80001006 -> both stale responses dropped, first fetch_addr 0x80001004, no stale word on fetch_valid.
REQ-042 SHALL test gnt withheld 3 cycles with branch in cycle 1 -> instr_addr stable until grant, granted word dropped, next request to branch target.
REQ-043 SHALL test wrap: boot_addr=0xFFFFFFF8 -> fetch_addr sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-044 SHALL test error: instr_err=1 on second response -> fetch_err=1 only with that word's fetch_addr.
